// File: rtl/pattern_pkg.sv
// -----------------------------------------------------------------------------
// pattern_pkg
// Shared definitions for the pattern drain path.
//   DEF_DATA_W      : default FIFO word width
//   DEF_OUT_W       : default beat width toward the imager
//   DEF_NUM_STREAMS : default FIFO words per pattern
//   BEATS           : beats per FIFO word at the default widths
//   state_t         : drain FSM state encoding
// -----------------------------------------------------------------------------
package pattern_pkg;

  localparam int DEF_DATA_W      = 256;
  localparam int DEF_OUT_W       = 32;
  localparam int DEF_NUM_STREAMS = 640;
  localparam int BEATS           = DEF_DATA_W / DEF_OUT_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/word_serializer.sv
// -----------------------------------------------------------------------------
// word_serializer
// Holds one wide word and hands it out as OUT_W beats, LSB slice first.
//   clk, rst     : clock, asynchronous active-low reset
//   load         : capture load_data this cycle (beat counter restarts at 0)
//   load_data    : word to capture
//   ready        : downstream accepts the current beat
//   data         : current beat (slice 'beat' of the held word)
//   valid        : a word is held, so data is a real beat
//   beat         : index of the beat currently presented
//   accept       : valid && ready this cycle
//   last_accept  : the final beat of the held word is accepted this cycle
//
// Handshake: a beat transfers on a cycle where valid && ready. While valid is
// high and ready is low, data and beat are held unchanged. valid never drops
// without a transfer of the last beat.
// -----------------------------------------------------------------------------
module word_serializer #(
  parameter int DATA_W = 256,
  parameter int OUT_W  = 32,
  localparam int NB    = DATA_W / OUT_W,
  localparam int BW    = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic [OUT_W-1:0]  data,
  output logic              valid,
  output logic [BW-1:0]     beat,
  output logic              accept,
  output logic              last_accept
);

  logic [NB-1:0][OUT_W-1:0] hold;
  logic                     hold_v;
  logic [BW-1:0]            beat_r;

  assign accept      = hold_v && ready;
  assign last_accept = accept && (beat_r == BW'(NB - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold   <= '0;
      hold_v <= 1'b0;
      beat_r <= '0;
    end else if (load) begin
      // A load may coincide with the last beat of the previous word being
      // accepted; that is what gives back-to-back words without a bubble.
      hold   <= load_data;
      hold_v <= 1'b1;
      beat_r <= '0;
    end else if (last_accept) begin
      hold_v <= 1'b0;
      beat_r <= '0;
    end else if (accept) begin
      beat_r <= beat_r + 1'b1;
    end
  end

  assign data  = hold[beat_r];
  assign valid = hold_v;
  assign beat  = beat_r;

endmodule

// File: rtl/pattern_unload.sv
// -----------------------------------------------------------------------------
// pattern_unload
// Drain side of the pattern FIFO: pops DATA_W words (first-word-fall-through)
// and serialises them into OUT_W beats for the imager mask loader. An exposure
// is Num_Pat patterns of NUM_STREAMS words each.
//   clk, rst    : clock, asynchronous active-low reset
//   start       : one-cycle exposure request, ignored unless idle
//   Num_Pat     : patterns in the exposure, captured when start is taken
//   fifo_dout   : FIFO head word, valid while fifo_empty is low
//   fifo_empty  : FIFO has no word
//   fifo_rd_en  : pop the FIFO head this cycle
//   pat_out     : beat data
//   pat_valid   : beat valid
//   pat_ready   : imager takes the beat
//   pat_sop     : first beat of a pattern
//   pat_eop     : last beat of a pattern
//   pat_last    : last beat of the exposure
//   busy        : exposure in progress
//   done        : one-cycle pulse once the final beat has been taken
//   dbg_state   : current FSM state
//
// Handshake: a beat transfers when pat_valid && pat_ready. pat_out and all
// three markers stay frozen while pat_valid is high and pat_ready is low.
// -----------------------------------------------------------------------------
module pattern_unload
  import pattern_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int OUT_W       = DEF_OUT_W,
  parameter int NUM_STREAMS = DEF_NUM_STREAMS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       Num_Pat,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [OUT_W-1:0]  pat_out,
  output logic              pat_valid,
  input  logic              pat_ready,
  output logic              pat_sop,
  output logic              pat_eop,
  output logic              pat_last,
  output logic              busy,
  output logic              done,
  output state_t            dbg_state
);

  localparam int WORD_BEATS = DATA_W / OUT_W;
  localparam int BW         = (WORD_BEATS > 1) ? $clog2(WORD_BEATS) : 1;
  localparam int WW         = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

  state_t        state, state_nxt;
  logic [31:0]   npat_r;
  logic [31:0]   pattern_r;
  logic [WW-1:0] word_r;
  logic [63:0]   pop_cnt;
  logic [63:0]   pop_total;
  logic          busy_r;

  logic          load;
  logic          accept;
  logic          last_accept;
  logic [BW-1:0] beat;
  logic          take_start;
  logic          final_accept;

  word_serializer #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W)
  ) u_ser (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_data   (fifo_dout),
    .ready       (pat_ready),
    .data        (pat_out),
    .valid       (pat_valid),
    .beat        (beat),
    .accept      (accept),
    .last_accept (last_accept)
  );

  assign take_start = (state == S_IDLE) && start;

  // Refill the holding register when it is empty or its last beat leaves
  // this cycle; the pop budget stops us from reading into the next exposure.
  assign load = (state == S_STREAM) && !fifo_empty && (pop_cnt < pop_total) &&
                (!pat_valid || last_accept);
  assign fifo_rd_en = load;

  assign pat_sop  = pat_valid && (word_r == '0) && (beat == '0);
  assign pat_eop  = pat_valid && (word_r == WW'(NUM_STREAMS - 1)) &&
                    (beat == BW'(WORD_BEATS - 1));
  // npat_r is never 0 while streaming, but the guard keeps npat_r-1 from
  // wrapping into a false match.
  assign pat_last = pat_eop && (npat_r != 32'd0) && (pattern_r == npat_r - 32'd1);

  assign final_accept = accept && pat_last;

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (Num_Pat == 32'd0) ? S_DONE : S_STREAM;
      end
      S_STREAM: begin
        if (final_accept) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      npat_r    <= '0;
      pattern_r <= '0;
      word_r    <= '0;
      pop_cnt   <= '0;
      pop_total <= '0;
      busy_r    <= 1'b0;
    end else begin
      state <= state_nxt;

      if (take_start) begin
        npat_r    <= Num_Pat;
        pop_total <= 64'(NUM_STREAMS) * {32'd0, Num_Pat};
        pop_cnt   <= '0;
        word_r    <= '0;
        pattern_r <= '0;
      end

      if (load) pop_cnt <= pop_cnt + 64'd1;

      // Word/pattern position advances only when a word's last beat leaves.
      if (last_accept) begin
        if (pat_eop) begin
          word_r    <= '0;
          pattern_r <= pattern_r + 32'd1;
        end else begin
          word_r <= word_r + 1'b1;
        end
      end

      // busy drops as the exposure finishes. An empty exposure spends its
      // single busy cycle in S_DONE alongside the done pulse.
      if (take_start)                              busy_r <= 1'b1;
      else if ((state == S_STREAM) && final_accept) busy_r <= 1'b0;
      else if (state == S_DONE)                     busy_r <= 1'b0;
    end
  end

  assign busy      = busy_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_pattern_unload.sv
module tb_pattern_unload;
  import pattern_pkg::*;

  localparam int DW        = 256;
  localparam int OW        = 32;
  localparam int NS        = 4;
  localparam int NB        = DW / OW;
  localparam int PAT_BEATS = NS * NB;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   Num_Pat = 32'd0;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [OW-1:0] pat_out;
  logic          pat_valid;
  logic          pat_ready = 1'b1;
  logic          pat_sop, pat_eop, pat_last;
  logic          busy, done;
  state_t        dbg_state;

  always #5 clk = ~clk;

  pattern_unload #(
    .DATA_W      (DW),
    .OUT_W       (OW),
    .NUM_STREAMS (NS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .Num_Pat    (Num_Pat),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .pat_out    (pat_out),
    .pat_valid  (pat_valid),
    .pat_ready  (pat_ready),
    .pat_sop    (pat_sop),
    .pat_eop    (pat_eop),
    .pat_last   (pat_last),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- FIFO model (first-word-fall-through) ----------------
  logic [DW-1:0] fmem [0:63];
  logic [5:0]    wr_ptr = '0;
  logic [5:0]    rd_ptr = '0;
  logic          flush = 1'b0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_dout  = fmem[rd_ptr];

  initial forever begin
    @(posedge clk);
    if (flush) rd_ptr <= wr_ptr;
    else if (fifo_rd_en && !fifo_empty) rd_ptr <= rd_ptr + 6'd1;
  end

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // word k carries beat values k*16+i in slice i
  task automatic push_word(input int k);
    logic [DW-1:0] w;
    logic [OW-1:0] b;
    for (int i = 0; i < NB; i++) begin
      b = OW'(k * 16 + i);
      w[i*OW +: OW] = b;
      exp_q.push_back(b);
    end
    fmem[wr_ptr] = w;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  // ---------------- monitor ----------------
  int beat_base = 0;
  int exp_total = 0;
  int acc_beats = 0;
  int pops = 0;
  int valid_cycles = 0;
  int gap_cycles = 0;
  logic          stall_prev = 1'b0;
  logic [OW-1:0] prev_out;
  logic [2:0]    prev_flags;

  initial forever begin
    int bi;
    @(negedge clk);
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      bi = acc_beats - beat_base;
      if (stall_prev) begin
        check("stall_valid", pat_valid, 1);
        check("stall_data", pat_out, prev_out);
        check("stall_flags", {pat_sop, pat_eop, pat_last}, prev_flags);
      end
      if (pat_valid && pat_ready) begin
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else check("beat_data", pat_out, exp_q.pop_front());
        check("beat_sop", pat_sop, (bi % PAT_BEATS) == 0);
        check("beat_eop", pat_eop, (bi % PAT_BEATS) == PAT_BEATS - 1);
        check("beat_last", pat_last, bi == exp_total - 1);
        acc_beats++;
      end
      stall_prev = pat_valid && !pat_ready;
      prev_out   = pat_out;
      prev_flags = {pat_sop, pat_eop, pat_last};
      if (fifo_rd_en) begin
        check("pop_nonempty", fifo_empty, 0);
        pops++;
      end
      if (pat_valid) valid_cycles++;
      if (busy && !pat_valid && bi > 0) gap_cycles++;
    end
  end

  logic toggle_en = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    if (toggle_en) pat_ready = ~pat_ready;
  end

  // ---------------- driver tasks ----------------
  int pop_base, vc_base, gap_base;

  task automatic do_start(input logic [31:0] n);
    exp_total = int'(n) * PAT_BEATS;
    beat_base = acc_beats;
    pop_base  = pops;
    vc_base   = valid_cycles;
    gap_base  = gap_cycles;
    @(posedge clk); #1;
    start = 1'b1;
    Num_Pat = n;
    @(posedge clk); #1;
    start = 1'b0;
    Num_Pat = 32'hDEAD_BEEF;
  endtask

  task automatic wait_done(input int budget, output int dc);
    bit seen;
    seen = 0;
    dc = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        dc = cyc;
      end
    end
    check("done_seen", seen, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    int fc, dc;

    // reset state
    #12;
    check("rst_valid", pat_valid, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_busy_done", {busy, done}, 0);
    check("rst_out", pat_out, 0);
    check("rst_state", dbg_state, S_IDLE);
    @(posedge clk); #1 rst = 1'b1;

    // T1: two patterns, full FIFO, ready held high
    pat_ready = 1'b1;
    for (int k = 0; k < 8; k++) push_word(k);
    do_start(2);
    @(negedge clk);
    check("t1_busy", busy, 1);
    check("t1_no_valid_yet", pat_valid, 0);
    @(negedge clk);
    check("t1_first_valid", pat_valid, 1);
    fc = cyc;
    wait_done(200, dc);
    check("t1_done_time", 64'(dc - fc), 64);
    check("t1_busy_at_done", busy, 0);
    @(negedge clk);
    check("t1_done_pulse", done, 0);
    check("t1_pops", 64'(pops - pop_base), 8);
    check("t1_beats", 64'(acc_beats - beat_base), 64);
    check("t1_q_empty", 64'(exp_q.size()), 0);

    // T2: ready toggling every cycle
    for (int k = 8; k < 16; k++) push_word(k);
    toggle_en = 1'b1;
    do_start(2);
    wait_done(400, dc);
    toggle_en = 1'b0;
    #2 pat_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("t2_pops", 64'(pops - pop_base), 8);
    check("t2_beats", 64'(acc_beats - beat_base), 64);
    check("t2_q_empty", 64'(exp_q.size()), 0);

    // T3: FIFO starts empty, one word every 20 cycles
    do_start(1);
    fork
      begin
        for (int j = 0; j < 4; j++) begin
          repeat (20) @(posedge clk);
          #1 push_word(16 + j);
        end
      end
      wait_done(300, dc);
    join
    check("t3_pops", 64'(pops - pop_base), 4);
    check("t3_beats", 64'(acc_beats - beat_base), 32);
    check("t3_gaps", 64'(gap_cycles - gap_base > 0), 1);
    check("t3_q_empty", 64'(exp_q.size()), 0);

    // T4: empty exposure
    do_start(0);
    @(negedge clk);
    check("t4_busy", busy, 1);
    check("t4_done", done, 1);
    @(negedge clk);
    check("t4_after", {busy, done}, 0);
    repeat (5) @(negedge clk);
    check("t4_pops", 64'(pops - pop_base), 0);
    check("t4_valid", 64'(valid_cycles - vc_base), 0);

    // T5: reset after 13 beats, then a fresh single-pattern exposure
    for (int k = 24; k < 32; k++) push_word(k);
    do_start(2);
    for (int i = 0; i < 100 && (acc_beats - beat_base) < 13; i++) @(negedge clk);
    check("t5_reached_13", 64'(acc_beats - beat_base), 13);
    #2 rst = 1'b0;
    #1;
    check("t5_rst_valid", pat_valid, 0);
    check("t5_rst_out", pat_out, 0);
    check("t5_rst_ctl", {fifo_rd_en, busy, done}, 0);
    check("t5_rst_flags", {pat_sop, pat_eop, pat_last}, 0);
    check("t5_rst_state", dbg_state, S_IDLE);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    for (int k = 32; k < 36; k++) push_word(k);
    rst = 1'b1;
    do_start(1);
    wait_done(200, dc);
    check("t5_pops", 64'(pops - pop_base), 4);
    check("t5_beats", 64'(acc_beats - beat_base), 32);
    check("t5_q_empty", 64'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_unload.md
Name: pattern_unload

Overview:
- Drain side of the pattern FIFO: pops 256-bit pattern words and serialises each into 32-bit beats for the imager mask-loading interface.
- Uses a valid/ready handshake downstream.
- Frames the stream as Num_Pat patterns of NUM_STREAMS words each, with start-of-pattern, end-of-pattern and end-of-exposure markers.
- Sits between the pattern FIFO read port and the imager pattern shifter.

Parameters:
- DATA_W, 256, FIFO word width
- OUT_W, 32, beat width; DATA_W must be a multiple of OUT_W
- BEATS, DATA_W/OUT_W (8), beats per FIFO word (derived)
- NUM_STREAMS, 640, FIFO words per pattern (5120 beats)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to begin an exposure; ignored while busy
- Num_Pat  in  32  patterns per exposure; sampled when start is accepted
- fifo_dout  in  DATA_W  FIFO head word, first-word-fall-through; valid when fifo_empty=0
- fifo_empty  in  1  pattern FIFO empty
- fifo_rd_en  out  1  pop FIFO head this cycle
- pat_out  out  OUT_W  beat data
- pat_valid  out  1  beat valid
- pat_ready  in  1  imager accepts beat when pat_valid&&pat_ready
- pat_sop  out  1  qualifies first beat of each pattern
- pat_eop  out  1  qualifies last beat of each pattern
- pat_last  out  1  qualifies final beat of exposure
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after final beat accepted

Behaviour:
- Reset (rst=0, async): state S_IDLE. All outputs are 0. Holding register, beat, word and pattern counters are cleared. Mid-exposure reset abandons the exposure; FIFO contents are left untouched.
- States: S_IDLE, S_STREAM, S_DONE.
- S_IDLE + start=1 latches Num_Pat into npat_r and sets busy next cycle.
  - If Num_Pat=0: go to S_DONE and issue zero pops.
  - Otherwise: go to S_STREAM.
- S_STREAM:
  - Holding register hold/hold_v. Load when fifo_empty=0 and either hold_v=0 or the last beat (beat=BEATS-1) is being accepted this cycle. This gives back-to-back words with no bubble.
  - A load pulses fifo_rd_en for exactly that cycle and sets beat=0.
  - Pops stop once the total NUM_STREAMS*npat_r words have been popped; never over-read.
  - pat_out = hold[beat*OUT_W +: OUT_W], LSB slice first; pat_valid = hold_v.
  - pat_out/flags hold stable while pat_valid=1 and pat_ready=0.
  - Accept increments beat. At beat=BEATS-1, hold_v clears unless reloaded in the same cycle.
  - pat_sop = hold_v && word=0 && beat=0.
  - pat_eop = hold_v && word=NUM_STREAMS-1 && beat=BEATS-1.
  - pat_last = pat_eop && pattern=npat_r-1.
  - An accepted eop wraps word to 0 and increments pattern.
  - An accepted pat_last moves to S_DONE.
- S_DONE: done=1 for one cycle, busy=0, return to S_IDLE.
- Latency: start at edge t → S_STREAM at t+1 → earliest fifo_rd_en at t+1 → first pat_valid at t+2.
- FIFO empty mid-pattern: pat_valid drops after the current word drains and resumes on refill. No data is lost or duplicated.
- Counter widths:
  - word: clog2(NUM_STREAMS)
  - beat: clog2(BEATS)
  - pattern: 32 bits; compare against npat_r-1 only when npat_r≠0.
- start while busy is ignored; Num_Pat changes during an exposure have no effect.

Decomposition:
- Shared package pattern_pkg holds:
  - DATA_W/OUT_W/NUM_STREAMS defaults
  - state encodings S_IDLE/S_STREAM/S_DONE
  - a localparam BEATS
- One natural sub-module: word_serializer (holding register + beat counter + load/accept handshake, DATA_W→OUT_W).
- The top-level module owns the FSM and the word/pattern counters.

Test Plan:
- NUM_STREAMS=4, Num_Pat=2, FIFO preloaded with 8 words, pat_ready=1:
  - 64 beats on consecutive cycles, first at start+2.
  - Exactly 8 fifo_rd_en pulses.
  - pat_sop on beats 0 and 32; pat_eop on beats 31 and 63; pat_last only on beat 63.
  - done one cycle later.
- Word 0x…0000_0007_0000_0006_…_0000_0000 (slice i = i): beats emitted 0,1,…,7 in order.
- Same setup with pat_ready toggling 1/0 every cycle: data and flags stable while stalled; 64 unique beats; no extra pops.
- FIFO starts empty and 1 word is added every 20 cycles: pat_valid gaps occur, beat order is intact, fifo_rd_en never asserts while fifo_empty=1.
- Num_Pat=0, start: busy 1 cycle, done pulse, zero fifo_rd_en, pat_valid never 1.
- rst low after 13 beats: all outputs 0 asynchronously. A new start with Num_Pat=1 then streams a fresh sequence with pat_sop on the first beat.
